// File: rtl/asrv32_alu_arbiter_pkg.sv
// asrv32_alu_arbiter_pkg: shared ALU op encoding, arbiter FSM states and 2-way pick helper.
package asrv32_alu_arbiter_pkg;
   localparam int ALU_WIDTH = 14;
   localparam int ALU_ADD  = 0;
   localparam int ALU_SUB  = 1;
   localparam int ALU_SLT  = 2;
   localparam int ALU_SLTU = 3;
   localparam int ALU_XOR  = 4;
   localparam int ALU_OR   = 5;
   localparam int ALU_AND  = 6;
   localparam int ALU_SLL  = 7;
   localparam int ALU_SRL  = 8;
   localparam int ALU_SRA  = 9;
   localparam int ALU_EQ   = 10;
   localparam int ALU_NEQ  = 11;
   localparam int ALU_GE   = 12;
   localparam int ALU_GEU  = 13;
   typedef enum logic {ARB_IDLE = 1'b0, ARB_RESP = 1'b1} arb_state_t;
   // Round-robin winner: under contention the requester that did not win last time goes.
   function automatic logic rr_pick(input logic [1:0] req, input logic last);
      return req[1] & (~req[0] | ~last);
   endfunction
endpackage

// File: rtl/asrv32_rr_arb2.sv
// asrv32_rr_arb2: 2-way round-robin grant, combinational winner plus last_grant register.
// Define ASRV32_ALU_ARB_FIXED_PRIO_EN to make requester 0 always win contention.
module asrv32_rr_arb2
   import asrv32_alu_arbiter_pkg::*;
#(
   parameter logic RR_INIT = 1'b1
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic [1:0] i_req,
   input  logic       i_take,
   output logic       o_winner
);
   logic r_last;
`ifdef ASRV32_ALU_ARB_FIXED_PRIO_EN
   assign o_winner = i_req[1] & ~i_req[0];
`else
   assign o_winner = rr_pick(i_req, r_last);
`endif
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) r_last <= RR_INIT;
      else if (i_take) r_last <= o_winner;
endmodule

// File: rtl/asrv32_alu_arbiter.sv
// asrv32_alu_arbiter: shares the asrv32 ALU between execute (r0) and branch/address unit (r1).
// Define ASRV32_ALU_ARB_FIXED_PRIO_EN (in asrv32_rr_arb2) for fixed r0 priority instead of round robin.
module asrv32_alu_arbiter
   import asrv32_alu_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int RR_INIT    = 1
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_r0_valid,
   output logic                  o_r0_ready,
   input  logic [ALU_WIDTH-1:0]  i_r0_alu,
   input  logic [DATA_WIDTH-1:0] i_r0_op1,
   input  logic [DATA_WIDTH-1:0] i_r0_op2,
   output logic                  o_r0_rvalid,
   input  logic                  i_r0_rready,
   output logic [DATA_WIDTH-1:0] o_r0_result,
   input  logic                  i_r1_valid,
   output logic                  o_r1_ready,
   input  logic [ALU_WIDTH-1:0]  i_r1_alu,
   input  logic [DATA_WIDTH-1:0] i_r1_op1,
   input  logic [DATA_WIDTH-1:0] i_r1_op2,
   output logic                  o_r1_rvalid,
   input  logic                  i_r1_rready,
   output logic [DATA_WIDTH-1:0] o_r1_result,
   output logic                  o_alu_en,
   output logic [ALU_WIDTH-1:0]  o_alu,
   output logic [DATA_WIDTH-1:0] o_op1,
   output logic [DATA_WIDTH-1:0] o_op2,
   input  logic [DATA_WIDTH-1:0] i_alu_result,
   output logic                  o_busy
);
   arb_state_t r_state;
   logic       r_owner;
   logic       w_winner;
   logic       w_issue;
   logic       w_done;
   asrv32_rr_arb2 #(.RR_INIT(1'(RR_INIT))) u_arb (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_req    ({i_r1_valid, i_r0_valid}),
      .i_take   (w_issue),
      .o_winner (w_winner)
   );
   // Reset gates the handshake so every output reads 0 while i_rst_n is low.
   assign w_issue     = i_rst_n & (r_state == ARB_IDLE) & (i_r0_valid | i_r1_valid);
   assign w_done      = (r_state == ARB_RESP) & (r_owner ? i_r1_rready : i_r0_rready);
   assign o_r0_ready  = w_issue & ~w_winner;
   assign o_r1_ready  = w_issue & w_winner;
   assign o_alu_en    = w_issue;
   assign o_alu       = w_issue ? (w_winner ? i_r1_alu : i_r0_alu) : '0;
   assign o_op1       = w_issue ? (w_winner ? i_r1_op1 : i_r0_op1) : '0;
   assign o_op2       = w_issue ? (w_winner ? i_r1_op2 : i_r0_op2) : '0;
   assign o_busy      = r_state == ARB_RESP;
   assign o_r0_rvalid = o_busy & ~r_owner;
   assign o_r1_rvalid = o_busy & r_owner;
   assign o_r0_result = o_r0_rvalid ? i_alu_result : '0;
   assign o_r1_result = o_r1_rvalid ? i_alu_result : '0;
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         r_state <= ARB_IDLE;
         r_owner <= 1'b0;
      end else if (w_issue) begin
         r_state <= ARB_RESP;
         r_owner <= w_winner;
      end else if (w_done) r_state <= ARB_IDLE;
   a_r0_hold: assert property (@(posedge i_clk) disable iff (!i_rst_n) i_r0_valid && !o_r0_ready |=> i_r0_valid);
   a_r1_hold: assert property (@(posedge i_clk) disable iff (!i_rst_n) i_r1_valid && !o_r1_ready |=> i_r1_valid);
endmodule

// File: tb/tb_asrv32_alu_arbiter.sv
// tb_asrv32_alu_arbiter: directed checks of grant, response, backpressure and reset behaviour.
module tb_asrv32_alu_arbiter;
   import asrv32_alu_arbiter_pkg::*;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic r0_valid = 0, r0_rready = 0, r1_valid = 0, r1_rready = 0;
   logic [ALU_WIDTH-1:0] r0_alu = '0, r1_alu = '0, alu;
   logic [31:0] r0_op1 = 0, r0_op2 = 0, r1_op1 = 0, r1_op2 = 0;
   logic r0_ready, r1_ready, r0_rvalid, r1_rvalid, alu_en, busy;
   logic [31:0] r0_result, r1_result, op1, op2;
   logic [31:0] alu_res = '0;
   int checks = 0, errors = 0;

   always #5 clk = ~clk;

   asrv32_alu_arbiter dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_r0_valid(r0_valid), .o_r0_ready(r0_ready), .i_r0_alu(r0_alu), .i_r0_op1(r0_op1), .i_r0_op2(r0_op2),
      .o_r0_rvalid(r0_rvalid), .i_r0_rready(r0_rready), .o_r0_result(r0_result),
      .i_r1_valid(r1_valid), .o_r1_ready(r1_ready), .i_r1_alu(r1_alu), .i_r1_op1(r1_op1), .i_r1_op2(r1_op2),
      .o_r1_rvalid(r1_rvalid), .i_r1_rready(r1_rready), .o_r1_result(r1_result),
      .o_alu_en(alu_en), .o_alu(alu), .o_op1(op1), .o_op2(op2), .i_alu_result(alu_res), .o_busy(busy)
   );

   // Stand-in for asrv32_alu: result registered on the enable pulse, held otherwise.
   function automatic logic [31:0] alu_f(input logic [ALU_WIDTH-1:0] op, input logic [31:0] a, input logic [31:0] b);
      if (op[ALU_ADD]) return a + b;
      if (op[ALU_SUB]) return a - b;
      if (op[ALU_XOR]) return a ^ b;
      if (op[ALU_OR])  return a | b;
      if (op[ALU_AND]) return a & b;
      return '0;
   endfunction
   always @(posedge clk) if (alu_en) alu_res <= alu_f(alu, op1, op2);

   function automatic logic [ALU_WIDTH-1:0] oh(input int b);
      logic [ALU_WIDTH-1:0] v;
      v = '0;
      v[b] = 1'b1;
      return v;
   endfunction

   task automatic do_reset;
      rst_n = 0; r0_valid = 0; r1_valid = 0; r0_rready = 0; r1_rready = 0;
      @(negedge clk); @(negedge clk);
      rst_n = 1;
      @(negedge clk);
   endtask

   task automatic test_reset;
      rst_n = 0; r0_valid = 1; r1_valid = 1; r0_alu = oh(ALU_ADD); r0_op1 = 1; r0_op2 = 2;
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b want 0", busy); end
      checks++; if ({r0_ready, r1_ready} !== 2'b00) begin errors++; $display("FAIL reset ready: got %b want 00", {r0_ready, r1_ready}); end
      checks++; if ({r0_rvalid, r1_rvalid} !== 2'b00) begin errors++; $display("FAIL reset rvalid: got %b want 00", {r0_rvalid, r1_rvalid}); end
      checks++; if (alu_en !== 1'b0 || alu !== '0 || op1 !== 0) begin errors++; $display("FAIL reset alu mux: en %b alu %h op1 %h want 0", alu_en, alu, op1); end
      r0_valid = 0; r1_valid = 0;
      @(negedge clk);
      rst_n = 1;
      @(negedge clk);
      checks++; if (busy !== 1'b0 || alu_en !== 1'b0) begin errors++; $display("FAIL post reset idle: busy %b en %b want 0 0", busy, alu_en); end
   endtask

   task automatic test_single;
      r0_valid = 1; r0_alu = oh(ALU_ADD); r0_op1 = 5; r0_op2 = 7;
      #1;
      checks++; if (r0_ready !== 1'b1 || r1_ready !== 1'b0) begin errors++; $display("FAIL single ready: got %b%b want r0=1 r1=0", r0_ready, r1_ready); end
      checks++; if (alu_en !== 1'b1 || alu !== oh(ALU_ADD) || op1 !== 5 || op2 !== 7) begin errors++; $display("FAIL single issue: en %b alu %h op %0d,%0d want 1 ADD 5,7", alu_en, alu, op1, op2); end
      @(negedge clk);
      r0_valid = 0;
      #1;
      checks++; if (r0_rvalid !== 1'b1 || r0_result !== 32'd12) begin errors++; $display("FAIL single result: rvalid %b result %0d want 1 12", r0_rvalid, r0_result); end
      checks++; if (alu_en !== 1'b0 || r0_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL single resp: en %b ready %b busy %b want 0 0 1", alu_en, r0_ready, busy); end
      checks++; if (r1_rvalid !== 1'b0 || r1_result !== 0) begin errors++; $display("FAIL single nonowner: rvalid %b result %h want 0 0", r1_rvalid, r1_result); end
      r0_rready = 1;
      @(negedge clk);
      r0_rready = 0;
      #1;
      checks++; if (busy !== 1'b0 || r0_rvalid !== 1'b0) begin errors++; $display("FAIL single done: busy %b rvalid %b want 0 0", busy, r0_rvalid); end
   endtask

   task automatic test_contend;
      do_reset();
      r0_valid = 1; r0_alu = oh(ALU_SUB); r0_op1 = 10; r0_op2 = 3;
      r1_valid = 1; r1_alu = oh(ALU_XOR); r1_op1 = 32'hF0; r1_op2 = 32'h0F;
      #1;
      checks++; if (r0_ready !== 1'b1 || r1_ready !== 1'b0 || alu !== oh(ALU_SUB)) begin errors++; $display("FAIL contend first: ready %b%b alu %h want r0 SUB", r0_ready, r1_ready, alu); end
      @(negedge clk);
      r0_valid = 0;
      #1;
      checks++; if (r0_rvalid !== 1'b1 || r0_result !== 32'd7 || r1_ready !== 1'b0) begin errors++; $display("FAIL contend r0 result: rvalid %b result %0d r1_ready %b want 1 7 0", r0_rvalid, r0_result, r1_ready); end
      r0_rready = 1;
      @(negedge clk);
      r0_rready = 0;
      #1;
      checks++; if (r1_ready !== 1'b1 || alu !== oh(ALU_XOR) || op1 !== 32'hF0) begin errors++; $display("FAIL contend second: r1_ready %b alu %h op1 %h want 1 XOR F0", r1_ready, alu, op1); end
      @(negedge clk);
      r1_valid = 0;
      #1;
      checks++; if (r1_rvalid !== 1'b1 || r1_result !== 32'hFF || r0_rvalid !== 1'b0) begin errors++; $display("FAIL contend r1 result: rvalid %b result %h want 1 FF", r1_rvalid, r1_result); end
      r1_rready = 1;
      @(negedge clk);
      r1_rready = 0;
   endtask

   task automatic test_round_robin;
      logic [3:0] exp_g;
      logic g;
      int n;
`ifdef ASRV32_ALU_ARB_FIXED_PRIO_EN
      exp_g = 4'b0000;
`else
      exp_g = 4'b1010;
`endif
      n = 0;
      r0_alu = oh(ALU_ADD); r0_op1 = 1; r0_op2 = 2;
      r1_alu = oh(ALU_SUB); r1_op1 = 9; r1_op2 = 4;
      r0_valid = 1; r1_valid = 1; r0_rready = 1; r1_rready = 1;
      while ((r0_valid || r1_valid) && n < 8) begin
         #1;
         g = r1_ready;
         checks++; if (r0_ready === r1_ready) begin errors++; $display("FAIL rr one grant op%0d: ready %b%b want exactly one", n, r0_ready, r1_ready); end
         if (n < 4) begin
            checks++; if (g !== exp_g[n]) begin errors++; $display("FAIL rr order op%0d: granted r%0d want r%0d", n, g, exp_g[n]); end
         end
         @(negedge clk);
         if (n >= 3) begin
            if (g) r1_valid = 0; else r0_valid = 0;
         end
         #1;
         checks++; if (alu_en !== 1'b0 || (g ? r1_result : r0_result) !== (g ? 32'd5 : 32'd3)) begin errors++; $display("FAIL rr resp op%0d: en %b result %0d want 0 %0d", n, alu_en, g ? r1_result : r0_result, g ? 5 : 3); end
         n++;
         @(negedge clk);
      end
      checks++; if (n !== 5) begin errors++; $display("FAIL rr op count: got %0d want 5", n); end
      r0_rready = 0; r1_rready = 0;
   endtask

   task automatic test_backpressure;
      r1_valid = 1; r1_alu = oh(ALU_AND); r1_op1 = 32'hFF00FF00; r1_op2 = 32'h0FF00FF0;
      #1;
      checks++; if (r1_ready !== 1'b1) begin errors++; $display("FAIL bp grant: r1_ready %b want 1", r1_ready); end
      @(negedge clk);
      r1_valid = 0;
      r0_valid = 1; r0_alu = oh(ALU_OR); r0_op1 = 1; r0_op2 = 2;
      for (int i = 0; i < 5; i++) begin
         #1;
         checks++; if (r1_rvalid !== 1'b1 || r1_result !== 32'h0F000F00 || r0_ready !== 1'b0) begin errors++; $display("FAIL bp hold c%0d: rvalid %b result %h r0_ready %b want 1 0F000F00 0", i, r1_rvalid, r1_result, r0_ready); end
         @(negedge clk);
      end
      r1_rready = 1;
      @(negedge clk);
      r1_rready = 0;
      #1;
      checks++; if (r0_ready !== 1'b1 || r1_rvalid !== 1'b0) begin errors++; $display("FAIL bp release: r0_ready %b r1_rvalid %b want 1 0", r0_ready, r1_rvalid); end
      @(negedge clk);
      r0_valid = 0;
      #1;
      checks++; if (r0_rvalid !== 1'b1 || r0_result !== 32'd3) begin errors++; $display("FAIL bp r0 result: rvalid %b result %0d want 1 3", r0_rvalid, r0_result); end
      r0_rready = 1;
      @(negedge clk);
      r0_rready = 0;
   endtask

   task automatic test_reset_mid;
      r0_valid = 1; r0_alu = oh(ALU_ADD); r0_op1 = 5; r0_op2 = 7;
      @(negedge clk);
      r0_valid = 0;
      #1;
      checks++; if (r0_rvalid !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL midreset pre: rvalid %b busy %b want 1 1", r0_rvalid, busy); end
      rst_n = 0;
      #1;
      checks++; if (busy !== 1'b0 || r0_rvalid !== 1'b0 || r1_rvalid !== 1'b0) begin errors++; $display("FAIL midreset async: busy %b rvalid %b%b want 0 00", busy, r0_rvalid, r1_rvalid); end
      @(negedge clk); @(negedge clk);
      rst_n = 1;
      @(negedge clk);
      #1;
      checks++; if (r0_rvalid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL midreset stale: rvalid %b busy %b want 0 0", r0_rvalid, busy); end
      @(negedge clk);
   endtask

   task automatic test_back_to_back;
      r0_valid = 1; r0_alu = oh(ALU_ADD); r0_op1 = 1; r0_op2 = 1;
      #1;
      checks++; if (alu_en !== 1'b1 || r0_ready !== 1'b1) begin errors++; $display("FAIL b2b issue: en %b ready %b want 1 1", alu_en, r0_ready); end
      @(negedge clk);
      r0_valid = 0; r0_rready = 1;
      r1_valid = 1; r1_alu = oh(ALU_XOR); r1_op1 = 3; r1_op2 = 1;
      #1;
      checks++; if (alu_en !== 1'b0 || r1_ready !== 1'b0 || r0_rvalid !== 1'b1 || r0_result !== 32'd2) begin errors++; $display("FAIL b2b resp: en %b r1_ready %b rvalid %b result %0d want 0 0 1 2", alu_en, r1_ready, r0_rvalid, r0_result); end
      @(negedge clk);
      r0_rready = 0;
      #1;
      checks++; if (alu_en !== 1'b1 || r1_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL b2b regrant: en %b r1_ready %b busy %b want 1 1 0", alu_en, r1_ready, busy); end
      @(negedge clk);
      r1_valid = 0;
      #1;
      checks++; if (alu_en !== 1'b0 || r1_rvalid !== 1'b1 || r1_result !== 32'd2) begin errors++; $display("FAIL b2b r1 result: en %b rvalid %b result %0d want 0 1 2", alu_en, r1_rvalid, r1_result); end
      r1_rready = 1;
      @(negedge clk);
      r1_rready = 0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_contend();
      test_round_robin();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
